apb_to_rbi_bridge: RTL and testbench

Upstream manager for the register bus: converts APB (v4, with strobes) accesses into single RBI read/write transactions on an `rbi_if` manager port, so a register bank on the subordinate side can be reached from the SoC peripheral bus. One APB transfer produces exactly one RBI transaction. A timeout counter protects APB from a subordinate that never acknowledges.

---
 rtl/apb_to_rbi_bridge.sv | 189 ++++++++++++++++++
 tb/tb_apb_to_rbi_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_rbi_bridge.sv
// rtl/apb_to_rbi_bridge.sv - APB4 subordinate to RBI manager bridge with ack timeout
//
// Purpose: turns each APB transfer into exactly one RBI read or write request,
// waits for the matching ack (or a timeout) and returns the result as a
// single-cycle pready pulse. All outputs are registered.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   psel, penable     APB select / access phase
//   pwrite            APB direction (1 = write)
//   paddr, pwdata     APB address / write data
//   pstrb             APB byte strobes
//   pready            one-cycle transfer-complete pulse
//   prdata, pslverr   APB read data / error response
//   rbi_addr          RBI address
//   rbi_write_en      RBI write request
//   rbi_wdata         RBI write data
//   rbi_wbit_mask     RBI per-bit write enable (byte strobes expanded)
//   rbi_write_ack/err RBI write completion / error
//   rbi_read_en       RBI read request
//   rbi_read_ack/err  RBI read completion / error
//   rbi_rdata         RBI read data

module apb_to_rbi_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic [ADDR_WIDTH-1:0]   rbi_addr,
  output logic                    rbi_write_en,
  output logic [DATA_WIDTH-1:0]   rbi_wdata,
  output logic [DATA_WIDTH-1:0]   rbi_wbit_mask,
  input  logic                    rbi_write_ack,
  input  logic                    rbi_write_err,
  output logic                    rbi_read_en,
  input  logic                    rbi_read_ack,
  input  logic [DATA_WIDTH-1:0]   rbi_rdata,
  input  logic                    rbi_read_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // Keep the counter at least one bit wide so a disabled timeout still elaborates.
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] mask_exp;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  always_comb begin
    mask_exp = '0;
    for (int i = 0; i < STRB_W; i++) begin
      mask_exp[8*i +: 8] = {8{pstrb[i]}};
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    wen_d     = wen_q;
    ren_d     = ren_q;
    pready_d  = 1'b0;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          // Reads never carry a write mask onto the register bus.
          mask_d  = pwrite ? mask_exp : '0;
          wen_d   = pwrite;
          ren_d   = !pwrite;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // Only the ack matching the outstanding request counts; an ack in the
        // same cycle as the timeout limit takes priority over the timeout.
        if (wen_q && rbi_write_ack) begin
          wen_d     = 1'b0;
          pslverr_d = rbi_write_err;
          prdata_d  = '0;
          pready_d  = 1'b1;
          state_d   = ST_RESP;
        end else if (ren_q && rbi_read_ack) begin
          ren_d     = 1'b0;
          pslverr_d = rbi_read_err;
          prdata_d  = rbi_rdata;
          pready_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_inc;
          end
          if (TO_EN && (cnt_inc == CNT_LIMIT)) begin
            wen_d     = 1'b0;
            ren_d     = 1'b0;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            pready_d  = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign pready        = pready_q;
  assign prdata        = prdata_q;
  assign pslverr       = pslverr_q;
  assign rbi_addr      = addr_q;
  assign rbi_wdata     = wdata_q;
  assign rbi_wbit_mask = mask_q;
  assign rbi_write_en  = wen_q;
  assign rbi_read_en   = ren_q;

endmodule

// File: tb/tb_apb_to_rbi_bridge.sv
// tb/tb_apb_to_rbi_bridge.sv - self-checking bench for apb_to_rbi_bridge

module tb_apb_to_rbi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] rbi_addr, rbi_wdata, rbi_wbit_mask, rbi_rdata;
  logic        rbi_write_en, rbi_read_en;
  logic        rbi_write_ack, rbi_write_err, rbi_read_ack, rbi_read_err;

  int nchk = 0;
  int nfail = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;
  resp_t sb[$];

  always #5 clk = ~clk;

  apb_to_rbi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .rbi_addr(rbi_addr), .rbi_write_en(rbi_write_en),
    .rbi_wdata(rbi_wdata), .rbi_wbit_mask(rbi_wbit_mask),
    .rbi_write_ack(rbi_write_ack), .rbi_write_err(rbi_write_err),
    .rbi_read_en(rbi_read_en), .rbi_read_ack(rbi_read_ack),
    .rbi_rdata(rbi_rdata), .rbi_read_err(rbi_read_err)
  );

  // Observations of one transfer; cycle numbers are relative to the setup cycle 0.
  int          en_first, en_last, rdy_cyc;
  logic        rdy_after, overlap, perr;
  logic [31:0] prd, mask1, addr1, wdata1;
  resp_t       exp_r;

  task automatic idle_bus();
    rbi_write_ack = 1'b0; rbi_write_err = 1'b0;
    rbi_read_ack  = 1'b0; rbi_read_err  = 1'b0;
    rbi_rdata     = 32'h5555AAAA;
  endtask

  // Called just after a negedge; runs setup in this cycle and up to 12 REQ/RESP cycles.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int ack_cyc,
                          input logic [31:0] rdat, input logic err);
    en_first = -1; en_last = -1; rdy_cyc = -1; overlap = 1'b0;
    prd = '0; perr = 1'b0; mask1 = '0; addr1 = '0; wdata1 = '0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    for (int c = 1; c <= 12 && rdy_cyc < 0; c++) begin
      @(posedge clk); #1;
      penable       = 1'b1;
      rbi_write_ack = wr && (c == ack_cyc);
      rbi_read_ack  = !wr && (c == ack_cyc);
      rbi_write_err = rbi_write_ack && err;
      rbi_read_err  = rbi_read_ack && err;
      rbi_rdata     = rbi_read_ack ? rdat : 32'h5555AAAA;
      @(negedge clk);
      if (rbi_write_en || rbi_read_en) begin
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (rbi_write_en && rbi_read_en) overlap = 1'b1;
      if (c == 1) begin mask1 = rbi_wbit_mask; addr1 = rbi_addr; wdata1 = rbi_wdata; end
      if (pready) begin rdy_cyc = c; prd = prdata; perr = pslverr; end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    idle_bus();
    @(negedge clk);
    rdy_after = pready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++; if (pready !== 1'b0) begin nfail++; $display("FAIL reset_pready got %b exp 0", pready); end
    nchk++; if ({pslverr, prdata} !== 33'h0) begin nfail++; $display("FAIL reset_resp got %b/%h exp 0/0", pslverr, prdata); end
    nchk++; if ({rbi_write_en, rbi_read_en} !== 2'b00) begin nfail++; $display("FAIL reset_en got %b exp 00", {rbi_write_en, rbi_read_en}); end
    nchk++; if ({rbi_addr, rbi_wdata, rbi_wbit_mask} !== 96'h0) begin nfail++; $display("FAIL reset_rbi got %h/%h/%h exp 0", rbi_addr, rbi_wdata, rbi_wbit_mask); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_late_ack();
    sb.push_back('{data: 32'h0, err: 1'b0});
    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'b0101, 2, 32'h0, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if (mask1 !== 32'h00FF00FF) begin nfail++; $display("FAIL wr_mask got %h exp 00ff00ff", mask1); end
    nchk++; if ({addr1, wdata1} !== {32'h10, 32'hDEADBEEF}) begin nfail++; $display("FAIL wr_addr_data got %h/%h exp 10/deadbeef", addr1, wdata1); end
    nchk++; if (en_first !== 1 || en_last !== 2) begin nfail++; $display("FAIL wr_en_window got %0d..%0d exp 1..2", en_first, en_last); end
    nchk++; if (rdy_cyc !== 3) begin nfail++; $display("FAIL wr_pready_cycle got %0d exp 3", rdy_cyc); end
    nchk++; if ({prd, perr} !== exp_r) begin nfail++; $display("FAIL wr_resp got %h/%b exp %h/%b", prd, perr, exp_r.data, exp_r.err); end
    nchk++; if (rdy_after !== 1'b0) begin nfail++; $display("FAIL wr_pready_width got %b exp 0", rdy_after); end
  endtask

  task automatic test_read_same_cycle();
    sb.push_back('{data: 32'h12345678, err: 1'b0});
    apb_xfer(1'b0, 32'h20, 32'hFFFFFFFF, 4'b1111, 1, 32'h12345678, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if (mask1 !== 32'h0) begin nfail++; $display("FAIL rd_mask got %h exp 0", mask1); end
    nchk++; if (addr1 !== 32'h20) begin nfail++; $display("FAIL rd_addr got %h exp 20", addr1); end
    nchk++; if (en_first !== 1 || en_last !== 1) begin nfail++; $display("FAIL rd_en_window got %0d..%0d exp 1..1", en_first, en_last); end
    nchk++; if (rdy_cyc !== 2) begin nfail++; $display("FAIL rd_pready_cycle got %0d exp 2", rdy_cyc); end
    nchk++; if ({prd, perr} !== exp_r) begin nfail++; $display("FAIL rd_resp got %h/%b exp %h/%b", prd, perr, exp_r.data, exp_r.err); end
  endtask

  task automatic test_errors();
    sb.push_back('{data: 32'hA5A5A5A5, err: 1'b1});
    apb_xfer(1'b0, 32'h24, 32'h0, 4'b0000, 1, 32'hA5A5A5A5, 1'b1);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 2) begin nfail++; $display("FAIL rd_err got %h/%b @%0d exp %h/%b @2", prd, perr, rdy_cyc, exp_r.data, exp_r.err); end
    sb.push_back('{data: 32'h0, err: 1'b1});
    apb_xfer(1'b1, 32'h28, 32'hCAFEF00D, 4'b1111, 1, 32'h0, 1'b1);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 2) begin nfail++; $display("FAIL wr_err got %h/%b @%0d exp %h/%b @2", prd, perr, rdy_cyc, exp_r.data, exp_r.err); end
  endtask

  task automatic test_timeout();
    sb.push_back('{data: 32'h0, err: 1'b1});
    apb_xfer(1'b0, 32'h40, 32'h0, 4'b0000, 0, 32'h0, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if (en_first !== 1 || en_last !== 4) begin nfail++; $display("FAIL to_en_window got %0d..%0d exp 1..4", en_first, en_last); end
    nchk++; if (rdy_cyc !== 5) begin nfail++; $display("FAIL to_pready_cycle got %0d exp 5", rdy_cyc); end
    nchk++; if ({prd, perr} !== exp_r) begin nfail++; $display("FAIL to_resp got %h/%b exp %h/%b", prd, perr, exp_r.data, exp_r.err); end
    // Late ack in cycle 6 (now) must be ignored.
    rbi_read_ack = 1'b1; rbi_rdata = 32'h77778888;
    @(posedge clk); #1; idle_bus();
    @(negedge clk);
    nchk++; if ({pready, rbi_read_en, prdata} !== 34'h0) begin nfail++; $display("FAIL to_late_ack got %b/%b/%h exp 0/0/0", pready, rbi_read_en, prdata); end
    sb.push_back('{data: 32'h0BADF00D, err: 1'b0});
    apb_xfer(1'b0, 32'h44, 32'h0, 4'b0000, 4, 32'h0BADF00D, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 5 || en_last !== 4) begin nfail++; $display("FAIL to_ack_wins got %h/%b @%0d en_last %0d exp %h/%b @5 en_last 4", prd, perr, rdy_cyc, en_last, exp_r.data, exp_r.err); end
  endtask

  task automatic test_reset_mid_req();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h30; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    nchk++; if (rbi_read_en !== 1'b1) begin nfail++; $display("FAIL rst_pre_en got %b exp 1", rbi_read_en); end
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    nchk++; if ({pready, pslverr, prdata, rbi_addr, rbi_write_en, rbi_read_en, rbi_wdata, rbi_wbit_mask} !== 132'h0) begin
      nfail++; $display("FAIL rst_mid_outputs got en %b/%b addr %h mask %h exp all 0", rbi_write_en, rbi_read_en, rbi_addr, rbi_wbit_mask);
    end
    @(posedge clk); #1; rbi_read_ack = 1'b1; rbi_rdata = 32'hFEEDFACE;
    @(posedge clk); #1; idle_bus();
    @(negedge clk);
    nchk++; if ({pready, rbi_read_en, prdata} !== 34'h0) begin nfail++; $display("FAIL rst_late_ack got %b/%b/%h exp 0/0/0", pready, rbi_read_en, prdata); end
    sb.push_back('{data: 32'h600DCAFE, err: 1'b0});
    apb_xfer(1'b0, 32'h34, 32'h0, 4'b0000, 1, 32'h600DCAFE, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 2) begin nfail++; $display("FAIL rst_recover got %h/%b @%0d exp %h/%b @2", prd, perr, rdy_cyc, exp_r.data, exp_r.err); end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{data: 32'h0, err: 1'b0});
    apb_xfer(1'b1, 32'h50, 32'h11112222, 4'b1100, 1, 32'h0, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 2 || overlap) begin nfail++; $display("FAIL b2b_write got %h/%b @%0d ovl %b exp %h/%b @2 ovl 0", prd, perr, rdy_cyc, overlap, exp_r.data, exp_r.err); end
    nchk++; if (mask1 !== 32'hFFFF0000) begin nfail++; $display("FAIL b2b_mask got %h exp ffff0000", mask1); end
    sb.push_back('{data: 32'h33334444, err: 1'b0});
    apb_xfer(1'b0, 32'h54, 32'h0, 4'b0000, 2, 32'h33334444, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 3 || en_first !== 1 || overlap) begin nfail++; $display("FAIL b2b_read got %h/%b @%0d first %0d ovl %b exp %h/%b @3 first 1 ovl 0", prd, perr, rdy_cyc, en_first, overlap, exp_r.data, exp_r.err); end
  endtask

  task automatic test_stray_ack();
    rbi_read_ack = 1'b1; rbi_read_err = 1'b1; rbi_write_ack = 1'b1; rbi_write_err = 1'b1;
    rbi_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; idle_bus();
    @(negedge clk);
    nchk++; if ({pready, rbi_write_en, rbi_read_en, pslverr} !== 4'b0) begin nfail++; $display("FAIL stray_ack got rdy %b en %b/%b err %b exp 0", pready, rbi_write_en, rbi_read_en, pslverr); end
    nchk++; if (prdata !== 32'h33334444) begin nfail++; $display("FAIL stray_prdata got %h exp 33334444", prdata); end
    sb.push_back('{data: 32'h9ABCDEF0, err: 1'b0});
    apb_xfer(1'b0, 32'h60, 32'h0, 4'b0000, 1, 32'h9ABCDEF0, 1'b0);
    exp_r = sb.pop_front();
    nchk++; if ({prd, perr} !== exp_r || rdy_cyc !== 2) begin nfail++; $display("FAIL stray_after got %h/%b @%0d exp %h/%b @2", prd, perr, rdy_cyc, exp_r.data, exp_r.err); end
  endtask

  initial begin
    test_reset();
    test_write_late_ack();
    test_read_same_cycle();
    test_errors();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    test_stray_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
